fft_frame_unloader: RTL and testbench

//  Sink end of the FFT output stream (dout_en/dout_cnt/dout_re/dout_im of the FFT top).

---
 rtl/fft_frame_unloader.sv | 188 ++++++++++++++++++
 tb/tb_fft_frame_unloader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_unloader.sv
// Sink for the FFT output stream: stores whole frames into a ping-pong RAM and
// re-emits each one in natural bin order over a valid/ready handshake.
module fft_frame_unloader #(
    parameter int WIDTH  = 16,
    parameter int NALL   = 9,
    parameter int BITREV = 1
) (
    input  logic                    clk,
    input  logic                    areset,
    input  logic                    din_en,
    input  logic [NALL-1:0]         din_cnt,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NALL-1:0]         out_idx,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    out_last,
    output logic [7:0]              drop_cnt
);

    localparam int              N        = 1 << NALL;
    localparam logic [NALL-1:0] LAST_IDX = {NALL{1'b1}};
    localparam logic [NALL-1:0] ONE      = NALL'(1);

    typedef enum logic [1:0] {W_SYNC, W_WRITE, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_STREAM} rd_state_t;

    wr_state_t wr_state;
    rd_state_t rd_state;

    logic [2*WIDTH-1:0] mem [2*N];
    logic [2*WIDTH-1:0] rd_data;
    logic [1:0]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic [NALL-1:0]    exp_cnt;
    logic [NALL-1:0]    rd_ptr;
    logic [NALL-1:0]    wr_addr;
    logic [NALL:0]      rd_addr;
    logic               start;
    logic               in_seq;
    logic               wr_en;
    logic               set_full;
    logic               clr_full;
    logic               xfer;
    logic               rd_en;

    function automatic logic [NALL-1:0] bit_reverse(input logic [NALL-1:0] v);
        logic [NALL-1:0] r;
        for (int i = 0; i < NALL; i++) r[i] = v[NALL-1-i];
        return r;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] v, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // A bin-0 sample in WRITE restarts a frame, so SYNC and WRITE share the start decode.
    assign wr_addr  = (BITREV != 0) ? bit_reverse(din_cnt) : din_cnt;
    assign start    = din_en && (din_cnt == '0) && !full[wr_bank] &&
                      (wr_state == W_SYNC || wr_state == W_WRITE);
    assign in_seq   = din_en && (wr_state == W_WRITE) && (din_cnt == exp_cnt);
    assign wr_en    = start || in_seq;
    assign set_full = in_seq && (exp_cnt == LAST_IDX);

    assign xfer     = out_valid && out_ready;
    assign clr_full = (rd_state == R_STREAM) && xfer && (out_idx == LAST_IDX);
    assign rd_en    = ((rd_state == R_IDLE) && full[rd_bank]) || (rd_state == R_LOAD) ||
                      ((rd_state == R_STREAM) && xfer);
    assign rd_addr  = (rd_state == R_IDLE) ? {rd_bank, {NALL{1'b0}}} : {rd_bank, rd_ptr};

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wr_bank, wr_addr}] <= {din_re, din_im};
        if (rd_en) rd_data <= mem[rd_addr];
    end

    // Writer and reader always touch different banks, so set and clear never collide.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            full <= '0;
        end else begin
            if (set_full) full[wr_bank] <= 1'b1;
            if (clr_full) full[rd_bank] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_state <= W_SYNC;
            exp_cnt  <= '0;
            wr_bank  <= 1'b0;
            drop_cnt <= '0;
        end else if (din_en) begin
            case (wr_state)
                W_SYNC: begin
                    if (din_cnt == '0) begin
                        if (!full[wr_bank]) begin
                            wr_state <= W_WRITE;
                            exp_cnt  <= ONE;
                        end else begin
                            drop_cnt <= sat_add(drop_cnt, 2'd1);
                            wr_state <= W_DROP;
                        end
                    end
                end
                W_WRITE: begin
                    if (din_cnt == exp_cnt) begin
                        if (exp_cnt == LAST_IDX) begin
                            wr_bank  <= ~wr_bank;
                            wr_state <= W_SYNC;
                        end else begin
                            exp_cnt <= exp_cnt + ONE;
                        end
                    end else if (din_cnt == '0) begin
                        if (!full[wr_bank]) begin
                            drop_cnt <= sat_add(drop_cnt, 2'd1);
                            exp_cnt  <= ONE;
                        end else begin
                            drop_cnt <= sat_add(drop_cnt, 2'd2);
                            wr_state <= W_DROP;
                        end
                    end else begin
                        drop_cnt <= sat_add(drop_cnt, 2'd1);
                        wr_state <= W_SYNC;
                    end
                end
                W_DROP: begin
                    if (din_cnt == LAST_IDX) wr_state <= W_SYNC;
                end
                default: wr_state <= W_SYNC;
            endcase
        end
    end

    // rd_data always holds the bin after the one on out_*, so transfers never bubble.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            rd_state  <= R_IDLE;
            rd_bank   <= 1'b0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (full[rd_bank]) begin
                        rd_ptr   <= ONE;
                        rd_state <= R_LOAD;
                    end
                end
                R_LOAD: begin
                    out_re    <= rd_data[2*WIDTH-1:WIDTH];
                    out_im    <= rd_data[WIDTH-1:0];
                    out_idx   <= '0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    rd_ptr    <= rd_ptr + ONE;
                    rd_state  <= R_STREAM;
                end
                R_STREAM: begin
                    if (xfer) begin
                        if (out_idx == LAST_IDX) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rd_bank   <= ~rd_bank;
                            rd_state  <= R_IDLE;
                        end else begin
                            out_re   <= rd_data[2*WIDTH-1:WIDTH];
                            out_im   <= rd_data[WIDTH-1:0];
                            out_idx  <= out_idx + ONE;
                            out_last <= ((out_idx + ONE) == LAST_IDX);
                            rd_ptr   <= rd_ptr + ONE;
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_unloader.sv
// Bench for fft_frame_unloader with N=8: a bit-reversed instance and a natural-order
// instance, each checked by a scoreboard monitor against hand-computed frames.
module tb_fft_frame_unloader;

    localparam int WIDTH = 16;
    localparam int NALL  = 3;
    localparam int REV [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    logic              clk = 1'b0;
    logic              areset = 1'b0;
    logic              din_en_rev = 1'b0;
    logic              din_en_nat = 1'b0;
    logic [NALL-1:0]   din_cnt = '0;
    logic [WIDTH-1:0]  din_re = '0;
    logic [WIDTH-1:0]  din_im = '0;
    logic              ready_rev = 1'b0;
    logic              ready_nat = 1'b0;

    logic              rev_valid, nat_valid, rev_last, nat_last;
    logic [NALL-1:0]   rev_idx, nat_idx;
    logic [WIDTH-1:0]  rev_re, rev_im, nat_re, nat_im;
    logic [7:0]        rev_drop, nat_drop;

    logic [35:0]       q_rev [$];
    logic [35:0]       q_nat [$];
    int                checks = 0;
    int                errors = 0;
    int                xfer_rev = 0;

    always #5 clk = ~clk;

    fft_frame_unloader #(.WIDTH(WIDTH), .NALL(NALL), .BITREV(1)) u_rev (
        .clk(clk), .areset(areset), .din_en(din_en_rev), .din_cnt(din_cnt),
        .din_re(din_re), .din_im(din_im), .out_valid(rev_valid), .out_ready(ready_rev),
        .out_idx(rev_idx), .out_re(rev_re), .out_im(rev_im), .out_last(rev_last),
        .drop_cnt(rev_drop)
    );

    fft_frame_unloader #(.WIDTH(WIDTH), .NALL(NALL), .BITREV(0)) u_nat (
        .clk(clk), .areset(areset), .din_en(din_en_nat), .din_cnt(din_cnt),
        .din_re(din_re), .din_im(din_im), .out_valid(nat_valid), .out_ready(ready_nat),
        .out_idx(nat_idx), .out_re(nat_re), .out_im(nat_im), .out_last(nat_last),
        .drop_cnt(nat_drop)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [35:0] mkBin(input int idx, input int v);
        return {3'(idx), 16'(v), 16'(-v), (idx == 7)};
    endfunction

    // Sends one frame (optionally skipping one index) and queues its expected output.
    task automatic applyStimulus(input bit nat, input int base, input int off_cycles,
                                 input int skip, input bit expect_out);
        for (int k = 0; k < 8; k++) begin
            if (k == skip) continue;
            din_cnt = 3'(k);
            din_re  = 16'(base + k);
            din_im  = 16'(-(base + k));
            if (nat) din_en_nat = 1'b1; else din_en_rev = 1'b1;
            @(posedge clk); #1;
            din_en_nat = 1'b0;
            din_en_rev = 1'b0;
            repeat (off_cycles) begin
                @(posedge clk); #1;
            end
        end
        if (expect_out) begin
            for (int i = 0; i < 8; i++) begin
                if (nat) q_nat.push_back(mkBin(i, base + i));
                else     q_rev.push_back(mkBin(i, base + REV[i]));
            end
        end
    endtask

    task automatic waitDrain(input bit nat, input int budget, input string name);
        int c = 0;
        while ((nat ? q_nat.size() : q_rev.size()) != 0 && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput(name, nat ? q_nat.size() : q_rev.size(), 0);
    endtask

    always @(negedge clk) begin
        if (areset && rev_valid) begin
            if (q_rev.size() == 0) begin
                checkOutput("rev_unexpected_valid", rev_valid, 0);
            end else begin
                checkOutput("rev_bin", {rev_idx, rev_re, rev_im, rev_last}, q_rev[0]);
                if (ready_rev) begin
                    void'(q_rev.pop_front());
                    xfer_rev++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (areset && nat_valid) begin
            if (q_nat.size() == 0) begin
                checkOutput("nat_unexpected_valid", nat_valid, 0);
            end else begin
                checkOutput("nat_bin", {nat_idx, nat_re, nat_im, nat_last}, q_nat[0]);
                if (ready_nat) void'(q_nat.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int start_x;
        int c;

        #3;
        checkOutput("reset_valid", rev_valid, 0);
        checkOutput("reset_last", rev_last, 0);
        checkOutput("reset_idx", rev_idx, 0);
        checkOutput("reset_re_im", {rev_re, rev_im}, 0);
        checkOutput("reset_drop", rev_drop, 0);
        @(posedge clk); #1;
        areset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] test 1: bit-reversed frame, latency");
        ready_rev = 1'b1;
        applyStimulus(0, 0, 0, -1, 1);
        @(negedge clk); checkOutput("lat_edge_t", rev_valid, 0);
        @(negedge clk); checkOutput("lat_edge_t1", rev_valid, 0);
        @(negedge clk); checkOutput("lat_edge_t2", rev_valid, 1);
        waitDrain(0, 40, "t1_drain");
        checkOutput("t1_drop", rev_drop, 0);

        $display("[TB] test 2: backpressure");
        ready_rev = 1'b0;
        applyStimulus(0, 16, 0, -1, 1);
        start_x = xfer_rev;
        c = 0;
        while (q_rev.size() != 0 && c < 100) begin
            ready_rev = (c % 3 == 0);
            @(posedge clk); #1;
            c++;
        end
        ready_rev = 1'b0;
        checkOutput("t2_drain", q_rev.size(), 0);
        checkOutput("t2_transfers", xfer_rev - start_x, 8);

        $display("[TB] test 3: three frames into full buffer");
        applyStimulus(0, 32, 0, -1, 1);
        applyStimulus(0, 48, 0, -1, 1);
        applyStimulus(0, 64, 0, -1, 0);
        @(negedge clk);
        checkOutput("t3_drop", rev_drop, 1);
        @(posedge clk); #1;
        ready_rev = 1'b1;
        waitDrain(0, 100, "t3_drain");

        $display("[TB] test 4: index gap aborts frame");
        applyStimulus(0, 80, 0, 3, 0);
        applyStimulus(0, 96, 0, -1, 1);
        waitDrain(0, 40, "t4_drain");
        checkOutput("t4_drop", rev_drop, 2);

        $display("[TB] test 5: reset during stream");
        ready_rev = 1'b0;
        applyStimulus(0, 112, 0, -1, 1);
        c = 0;
        while (!rev_valid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("t5_valid_seen", rev_valid, 1);
        ready_rev = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        ready_rev = 1'b0;
        @(negedge clk);
        checkOutput("t5_idx_before_reset", rev_idx, 3);
        #2;
        areset = 1'b0;
        #1;
        checkOutput("t5_reset_valid", rev_valid, 0);
        checkOutput("t5_reset_drop", rev_drop, 0);
        q_rev.delete();
        @(posedge clk); #1;
        areset = 1'b1;
        @(posedge clk); #1;
        ready_rev = 1'b1;
        applyStimulus(0, 128, 0, -1, 1);
        waitDrain(0, 40, "t5_drain");

        $display("[TB] test 6: natural order, gapped input");
        ready_nat = 1'b1;
        applyStimulus(1, 144, 2, -1, 1);
        waitDrain(1, 40, "t6_drain");
        checkOutput("t6_drop", nat_drop, 0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
